// File: rtl/or_gate_unit.sv
// or_gate_unit: registered bitwise OR of a and b with reduction flag,
// optional sticky accumulate and a one-entry valid/ready output stage.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   a, b          WIDTH-bit operands
//   in_valid      operands present this cycle
//   in_ready      unit can take operands this cycle
//   acc_en        OR this result into the running accumulator
//   acc_clr       drop the accumulator contents at the next edge
//   out, any      registered result and its reduction OR
//   out_valid     out/any hold a result
//   out_ready     downstream takes the result this cycle
//   popcnt        set-bit count of out (only with OR_GATE_POPCNT_EN)
//
// Build option: define OR_GATE_POPCNT_EN to add the popcnt output.
module or_gate_unit #(
    parameter int WIDTH = 1
`ifdef OR_GATE_POPCNT_EN
    ,
    localparam int PW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] out,
    output logic             any,
    output logic             out_valid,
    input  logic             out_ready
`ifdef OR_GATE_POPCNT_EN
    ,
    output logic [PW-1:0]    popcnt
`endif
);

    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] or_ab;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] load_val;

    // The slot frees up in the same cycle it drains, so a full
    // register still accepts when downstream is taking its value.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Clear wins over the old contents, but the operands arriving
    // with the clear are still folded in.
    assign acc_base = acc_clr ? '0 : acc_q;
    assign or_ab    = a | b;
    assign acc_next = or_ab | acc_base;
    assign load_val = acc_en ? acc_next : or_ab;

`ifdef OR_GATE_POPCNT_EN
    logic [PW-1:0] load_cnt;

    always_comb begin
        load_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_cnt = load_cnt + PW'(load_val[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            popcnt <= '0;
        end else if (accept) begin
            popcnt <= load_cnt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            any <= 1'b0;
        end else if (accept) begin
            out <= load_val;
            any <= |load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // A clear with no accumulating accept still empties the
    // accumulator; out is left alone in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept && acc_en) begin
            acc_q <= acc_next;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

endmodule

// File: tb/tb_or_gate_unit.sv
// tb_or_gate_unit: scoreboard bench for or_gate_unit (WIDTH=8),
// directed plan vectors followed by random traffic.
module tb_or_gate_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         acc_en = 1'b0;
    logic         acc_clr = 1'b0;
    logic [W-1:0] out;
    logic         any;
    logic         out_valid;
    logic         out_ready = 1'b0;
`ifdef OR_GATE_POPCNT_EN
    logic [3:0]   popcnt;
`endif

    or_gate_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out       (out),
        .any       (any),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef OR_GATE_POPCNT_EN
        ,
        .popcnt    (popcnt)
`endif
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] expq[$];
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] next_acc = '0;
    logic         m_valid = 1'b0;
    logic         next_valid = 1'b0;
    logic         m_in_ready = 1'b0;
    logic         flush = 1'b0;
    logic         chk_rst = 1'b0;
    logic         mon_en = 1'b0;
    logic         end_chk = 1'b0;

    // One cycle of stimulus; the model decides acceptance from its
    // own view of the output slot, never from the DUT.
    task automatic step(input logic r, input logic iv,
                        input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ae, input logic ac, input logic orr);
        logic [W-1:0] res;
        @(posedge clk);
        #1;
        m_valid = next_valid;
        m_acc   = next_acc;
        if (flush) begin
            expq.delete();
            flush   = 1'b0;
            chk_rst = 1'b1;
            mon_en  = 1'b1;
        end else begin
            chk_rst = 1'b0;
        end
        rst = r; in_valid = iv; a = ta; b = tb_;
        acc_en = ae; acc_clr = ac; out_ready = orr;
        m_in_ready = !m_valid || orr;
        if (r) begin
            next_valid = 1'b0;
            next_acc   = '0;
            flush      = 1'b1;
        end else if (iv && m_in_ready) begin
            if (ae) begin
                res      = ta | tb_ | (ac ? '0 : m_acc);
                next_acc = res;
            end else begin
                res      = ta | tb_;
                next_acc = ac ? '0 : m_acc;
            end
            expq.push_back(res);
            next_valid = 1'b1;
        end else begin
            next_acc   = ac ? '0 : m_acc;
            next_valid = m_valid && !orr;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (in_ready !== m_in_ready) begin
                errors++;
                $display("FAIL in_ready: got %b want %b", in_ready, m_in_ready);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
            end
            if (chk_rst) begin
                checks++;
                if (out !== '0 || any !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: out=%h any=%b want 0/0", out, any);
                end
`ifdef OR_GATE_POPCNT_EN
                checks++;
                if (popcnt !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_popcnt: got %0d want 0", popcnt);
                end
`endif
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out=%h with empty scoreboard", out);
                end else begin
                    checks++;
                    if (out !== expq[0]) begin
                        errors++;
                        $display("FAIL out: got %h want %h", out, expq[0]);
                    end
                    checks++;
                    if (any !== (expq[0] != '0)) begin
                        errors++;
                        $display("FAIL any: got %b want %b", any, expq[0] != '0);
                    end
`ifdef OR_GATE_POPCNT_EN
                    checks++;
                    if (popcnt !== 4'($countones(expq[0]))) begin
                        errors++;
                        $display("FAIL popcnt: got %0d want %0d", popcnt,
                                 $countones(expq[0]));
                    end
`endif
                    if (out_ready) void'(expq.pop_front());
                end
            end
            if (end_chk) begin
                checks++;
                if (expq.size() != 0) begin
                    errors++;
                    $display("FAIL drain: %0d results never delivered", expq.size());
                end
            end
        end
    end

    initial begin
        // reset, then WIDTH=1-style truth table on bit 0
        step(1, 0, 8'h00, 8'h00, 0, 0, 1);
        step(0, 1, 8'h00, 8'h00, 0, 0, 1);
        step(0, 1, 8'h00, 8'h01, 0, 0, 1);
        step(0, 1, 8'h01, 8'h00, 0, 0, 1);
        step(0, 1, 8'h01, 8'h01, 0, 0, 1);
        // reset while holding out=1 under backpressure
        step(0, 1, 8'h01, 8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 8'h00, 0, 0, 0);
        step(1, 0, 8'h00, 8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 8'h00, 0, 0, 1);
        // stall: second input must wait for the drain
        step(0, 1, 8'h0F, 8'hF0, 0, 0, 0);
        step(0, 1, 8'h3C, 8'h00, 0, 0, 0);
        step(0, 1, 8'h3C, 8'h00, 0, 0, 0);
        step(0, 1, 8'h3C, 8'h00, 0, 0, 1);
        step(0, 0, 8'h00, 8'h00, 0, 0, 1);
        // accumulate and clear-with-accept
        step(0, 1, 8'h01, 8'h00, 1, 0, 1);
        step(0, 1, 8'h04, 8'h00, 1, 0, 1);
        step(0, 1, 8'h00, 8'h00, 1, 0, 1);
        step(0, 1, 8'h10, 8'h00, 1, 1, 1);
        step(0, 1, 8'h00, 8'h00, 1, 0, 1);
        // bare clear, then popcnt vectors
        step(0, 0, 8'h00, 8'h00, 0, 1, 1);
        step(0, 1, 8'h00, 8'h00, 1, 0, 1);
        step(0, 1, 8'hA0, 8'h05, 0, 0, 1);
        step(0, 1, 8'h00, 8'h00, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) != 0),
                 W'($urandom), W'($urandom) & W'($urandom),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 1);
        end_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_gate_unit.md
Name: or_gate_unit

Overview:
- Registered, parameterised bitwise-OR datapath element: ORs two WIDTH-bit operands and presents the result one cycle later, together with a reduction-OR flag.
- Optional sticky accumulate mode ORs successive results into a running value, e.g. for error/status aggregation.
- One-entry output register with valid/ready handshake, so it drops into streaming pipelines.

Parameters:
- WIDTH, 1, operand and result width in bits (must be >= 1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  unit can accept operands this cycle.
- acc_en  input  1  sampled with an accepted input; 1 = OR result into the accumulator.
- acc_clr  input  1  clears the accumulator at the next edge.
- out  output  WIDTH  registered result.
- any  output  1  reduction OR of out, registered in step with out.
- out_valid  output  1  out/any hold a result.
- out_ready  input  1  downstream accepts the result this cycle.

Behaviour:
- Reset (rst=1 at an edge): out=0, any=0, out_valid=0, accumulator=0; rst overrides all other inputs that cycle.
- in_ready = !out_valid || out_ready (combinational). An input is accepted when in_valid && in_ready.
- Output register is loaded only on accepted input. Latency is exactly 1 cycle, from accept edge to out_valid=1.
- On accept with acc_en=0: out <= a | b; accumulator unchanged.
- On accept with acc_en=1: acc_next = a | b | acc_base; out <= acc_next; accumulator <= acc_next.
- acc_base = 0 if acc_clr=1 that cycle, else current accumulator. Clear has priority over old contents, but the new operands are still included.
- acc_clr without an accepted acc_en input: accumulator <= 0; out is untouched.
- any <= |(value loaded into out), updated only when out is loaded.
- out_valid: set on accept. Cleared when out_valid && out_ready && no new accept that cycle. Stays 1 on simultaneous drain and accept, with out replaced back-to-back.
- While out_valid=1 and out_ready=0: out, any and out_valid hold stable; in_ready=0.
- Inputs with in_valid=0 are ignored; X on a/b is tolerated when in_valid=0.
- Pure bitwise OR; no carries and no width growth.

Optional Feature:
- Macro OR_GATE_POPCNT_EN.
- Defined: adds output port popcnt, width $clog2(WIDTH+1) (minimum 1), equal to the number of set bits in the value loaded into out. It is registered with out, has reset value 0, and holds under backpressure.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=1, out_ready=1, in_valid=1, acc_en=0; apply (a,b) = (0,0),(0,1),(1,0),(1,1) on consecutive cycles -> out = 0,1,1,1 each one cycle later; any matches out; out_valid=1 from the cycle after the first accept.
- Reset with rst=1 while out_valid=1 and out=1 -> next cycle out=0, any=0, out_valid=0, accumulator=0.
- WIDTH=8, out_ready=0: accept a=8'h0F, b=8'hF0 -> out=8'hFF, any=1, in_ready=0. A second input presented while stalled is not accepted. Raise out_ready -> drains, then the second input is accepted and its result appears one cycle later.
- WIDTH=8, acc_en=1: accept (8'h01,8'h00), then (8'h04,8'h00), then (8'h00,8'h00) -> out = 8'h01, 8'h05, 8'h05.
- Then acc_clr=1 with accepted acc_en input (8'h10,8'h00) -> out=8'h10. A following input (8'h00,8'h00) with acc_en=1 -> out=8'h10.
- WIDTH=8, OR_GATE_POPCNT_EN defined: a=8'hA0, b=8'h05 -> out=8'hA5, popcnt=4. Input (8'h00,8'h00) -> out=0, any=0, popcnt=0.
